// File: rtl/out_bank_sequencer.sv
// Read-out sequencer for the 16-bank result memory: walks address-major/bank-minor,
// drives the 16:1 mux select and streams words through a 2-entry output buffer.
`ifndef D_width
`define D_width 16
`endif

module out_bank_sequencer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [4:0]          sel_out,
    input  logic [`D_width-1:0] mux_q,
    output logic                out_valid,
    output logic [`D_width-1:0] out_data,
    output logic                out_last,
    input  logic                out_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]          state;
    logic [3:0]          bank_cnt;
    logic [ADDR_W-1:0]   addr_cnt;
    logic                inflight;
    logic                inflight_last;
    logic [`D_width-1:0] buf_data [2];
    logic [1:0]          buf_last;
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic                pop;
    logic                issue_last;
    logic                finish;

    assign out_valid  = (count != 2'd0);
    assign out_data   = buf_data[rd_ptr];
    assign out_last   = out_valid && buf_last[rd_ptr];
    assign pop        = out_valid && out_ready;
    assign busy       = (state != S_IDLE);
    assign rd_addr    = addr_cnt;
    assign issue_last = (bank_cnt == 4'hf) && (addr_cnt == ADDR_LAST);
    assign finish     = (state == S_DRAIN) && pop && buf_last[rd_ptr];

    // Buffered plus in-flight words never exceed the two buffer slots; a pop this
    // cycle frees a slot immediately so rd_en can reassert without a bubble.
    assign rd_en = (state == S_RUN) &&
                   (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bank_cnt      <= 4'd0;
            addr_cnt      <= '0;
            sel_out       <= 5'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= finish;
            inflight      <= rd_en;
            inflight_last <= rd_en && issue_last;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        bank_cnt <= 4'd0;
                        addr_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (rd_en) begin
                        sel_out <= {1'b0, bank_cnt};
                        // Counters stop on the final read so rd_addr holds afterwards.
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end else begin
                            bank_cnt <= bank_cnt + 4'd1;
                            if (bank_cnt == 4'hf) begin
                                addr_cnt <= addr_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (finish) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            buf_last    <= 2'b00;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
        end else begin
            if (inflight) begin
                buf_data[wr_ptr] <= mux_q;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_out_bank_sequencer.sv
// Bench for out_bank_sequencer: cycle-indexed vector table plus an output scoreboard.
`ifndef D_width
`define D_width 16
`endif

module tb_out_bank_sequencer;

    localparam int DW = `D_width;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start4, start64, out_ready;

    logic          busy4, done4, rd_en4, valid4, last4;
    logic [1:0]    rd_addr4;
    logic [4:0]    sel4;
    logic [DW-1:0] mux_q4, data4;

    logic          busy64, done64, rd_en64, valid64, last64;
    logic [5:0]    rd_addr64;
    logic [4:0]    sel64_out;
    logic [DW-1:0] mux_q64, data64;

    out_bank_sequencer #(.DEPTH(4), .ADDR_W(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .sel_out(sel4), .mux_q(mux_q4),
        .out_valid(valid4), .out_data(data4), .out_last(last4), .out_ready(out_ready)
    );

    out_bank_sequencer #(.DEPTH(64), .ADDR_W(6)) u64 (
        .clk(clk), .rst(rst), .start(start64), .busy(busy64), .done(done64),
        .rd_en(rd_en64), .rd_addr(rd_addr64), .sel_out(sel64_out), .mux_q(mux_q64),
        .out_valid(valid64), .out_data(data64), .out_last(last64), .out_ready(out_ready)
    );

    // Bank model: word at (addr a, bank b) = 16*a+b, one-cycle read latency.
    logic [1:0] lat4;
    logic [5:0] lat64;
    always @(posedge clk) begin
        if (rd_en4)  lat4  <= rd_addr4;
        if (rd_en64) lat64 <= rd_addr64;
    end
    assign mux_q4  = DW'(lat4)  * DW'(16) + DW'(sel4[3:0]);
    assign mux_q64 = DW'(lat64) * DW'(16) + DW'(sel64_out[3:0]);

    logic          sel64;
    logic          o_busy, o_done, o_rd_en, o_valid, o_last;
    logic [5:0]    o_addr;
    logic [4:0]    o_sel;
    logic [DW-1:0] o_data;
    always_comb begin
        o_busy  = sel64 ? busy64    : busy4;
        o_done  = sel64 ? done64    : done4;
        o_rd_en = sel64 ? rd_en64   : rd_en4;
        o_valid = sel64 ? valid64   : valid4;
        o_last  = sel64 ? last64    : last4;
        o_addr  = sel64 ? rd_addr64 : {4'b0000, rd_addr4};
        o_sel   = sel64 ? sel64_out : sel4;
        o_data  = sel64 ? data64    : data4;
    end

    typedef struct {
        int   run;
        int   cyc;
        logic busy;
        logic rd_en;
        logic valid;
        logic done;
        int   addr;
        int   sel;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    vec_t          tbl[$];
    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            cur_run = 0;
    int            done_cnt = 0;
    bit            stall_prev = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic add(int run, int c, logic b, logic r, logic v, logic d, int a, int s);
        vec_t e;
        e.run = run; e.cyc = c; e.busy = b; e.rd_en = r; e.valid = v; e.done = d;
        e.addr = a; e.sel = s;
        tbl.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s run=%0d cyc=%0d got=%0h want=%0h", name, cur_run, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        if (o_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word run=%0d cyc=%0d got=%0h want=none", cur_run, cyc, o_data);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(o_data), 32'(e.data));
                chk("last", 32'(o_last), 32'(e.last));
            end
        end
        if (stall_prev) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_data", 32'(o_data), 32'(prev_data));
        end
        stall_prev = o_valid && !out_ready;
        prev_data  = o_data;
        if (o_done) done_cnt++;
        foreach (tbl[i]) begin
            if (tbl[i].run == cur_run && tbl[i].cyc == cyc) begin
                chk("busy",  32'(o_busy),  32'(tbl[i].busy));
                chk("rd_en", 32'(o_rd_en), 32'(tbl[i].rd_en));
                chk("valid", 32'(o_valid), 32'(tbl[i].valid));
                chk("done",  32'(o_done),  32'(tbl[i].done));
                if (tbl[i].addr >= 0) chk("rd_addr", 32'(o_addr), 32'(tbl[i].addr));
                if (tbl[i].sel >= 0)  chk("sel_out", 32'(o_sel),  32'(tbl[i].sel));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(int id, bit use64, int n_words, int stall_lo, int stall_hi,
                       bit rnd, int rst_at, bit want_done, int budget);
        int   done_at;
        exp_t e;
        done_at  = -1;
        sel64    = use64;
        cur_run  = id;
        cyc      = 0;
        done_cnt = 0;
        while (cyc < budget) begin
            start4    = !use64 && (cyc == 0 || (id == 3 && (cyc == 10 || cyc == 20)));
            start64   = use64 && (cyc == 0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
            rst       = (cyc == rst_at);
            if (cyc == 0) begin
                for (int k = 0; k < n_words; k++) begin
                    e.data = DW'(k);
                    e.last = (k == n_words - 1);
                    exp_q.push_back(e);
                end
            end
            step();
            if (cyc - 1 == rst_at) begin
                exp_q.delete();
                stall_prev = 0;
            end
            if (done_cnt > 0 && done_at < 0) done_at = cyc;
            if (done_at >= 0 && cyc >= done_at + 2) break;
        end
        rst = 0; start4 = 0; start64 = 0; out_ready = 1;
        if (want_done) begin
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("leftover", 32'(exp_q.size()), 32'd0);
            chk("idle_busy", 32'(o_busy), 32'd0);
        end
    endtask

    initial begin
        // run | cyc | busy rd_en valid done | rd_addr sel_out (-1 = don't care)
        add(1, 0, 0, 0, 0, 0, -1, -1);  add(1, 1, 1, 1, 0, 0, 0, -1);
        add(1, 2, 1, 1, 0, 0, 0, 0);    add(1, 3, 1, 1, 1, 0, -1, -1);
        add(1, 17, 1, 1, 1, 0, 1, -1);  add(1, 20, 1, 1, 1, 0, -1, 2);
        add(1, 49, 1, 1, 1, 0, 3, -1);  add(1, 64, 1, 1, 1, 0, 3, -1);
        add(1, 65, 1, 0, 1, 0, 3, 15);  add(1, 66, 1, 0, 1, 0, -1, -1);
        add(1, 67, 0, 0, 0, 1, 3, 15);  add(1, 68, 0, 0, 0, 0, 3, 15);
        add(2, 4, 1, 1, 1, 0, -1, -1);  add(2, 5, 1, 0, 1, 0, -1, -1);
        add(2, 10, 1, 0, 1, 0, -1, -1); add(2, 14, 1, 0, 1, 0, -1, -1);
        add(2, 15, 1, 1, 1, 0, -1, -1); add(2, 74, 1, 1, 1, 0, 3, -1);
        add(2, 75, 1, 0, 1, 0, -1, -1); add(2, 76, 1, 0, 1, 0, -1, -1);
        add(2, 77, 0, 0, 0, 1, -1, -1);
        add(3, 21, 1, 1, 1, 0, -1, -1); add(3, 66, 1, 0, 1, 0, -1, -1);
        add(3, 67, 0, 0, 0, 1, -1, -1);
        add(4, 29, 1, 1, 1, 0, 1, -1);  add(4, 31, 0, 0, 0, 0, 0, 0);
        add(4, 33, 0, 0, 0, 0, 0, 0);
        add(5, 1, 1, 1, 0, 0, 0, -1);   add(5, 67, 0, 0, 0, 1, -1, -1);

        // Reset held with start asserted: everything stays at reset values.
        sel64 = 0; rst = 1; start4 = 1; start64 = 1; out_ready = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy",  32'(busy4),    32'd0);
            chk("rst_done",  32'(done4),    32'd0);
            chk("rst_rd_en", 32'(rd_en4),   32'd0);
            chk("rst_addr",  32'(rd_addr4), 32'd0);
            chk("rst_sel",   32'(sel4),     32'd0);
            chk("rst_valid", 32'(valid4),   32'd0);
            chk("rst_data",  32'(data4),    32'd0);
            chk("rst_last",  32'(last4),    32'd0);
            chk("rst_busy64", 32'(busy64),  32'd0);
            @(posedge clk);
            #1;
        end
        rst = 0; start4 = 0; start64 = 0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy4), 32'd0);
        chk("post_rst_busy64", 32'(busy64), 32'd0);

        run(1, 0, 64, -1, -1, 0, -1, 1, 200);
        run(2, 0, 64, 5, 14, 0, -1, 1, 200);
        run(3, 0, 64, -1, -1, 0, -1, 1, 200);
        run(4, 0, 64, -1, -1, 0, 30, 0, 36);
        chk("after_rst_busy", 32'(busy4),  32'd0);
        chk("after_rst_data", 32'(data4),  32'd0);
        chk("after_rst_last", 32'(last4),  32'd0);
        chk("after_rst_valid", 32'(valid4), 32'd0);
        run(5, 0, 64, -1, -1, 0, -1, 1, 200);
        run(6, 1, 1024, -1, -1, 1, -1, 1, 6000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_bank_sequencer.md
# out_bank_sequencer

Read-out controller for the 16-bank result memory and its 16:1 output multiplexer. On `start` it walks every address of every bank in address-major, bank-minor order. It drives the bank read address/enable and the mux select `sel_out`, captures the mux output, and streams the words out over a valid/ready interface. A 2-entry output buffer lets downstream backpressure stall the walk without losing in-flight reads.

## Interface
Parameters:
- `DEPTH`, 64 — words per bank; total words per run = 16·DEPTH.
- `ADDR_W`, 6 — bank address width; DEPTH ≤ 2^ADDR_W.
- Data width is `` `D_width `` from `define.svh`.

Ports:
- `clk`  in  1  — sole clock.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — one-cycle request to begin a read-out run; ignored unless IDLE.
- `busy`  out  1  — high from the cycle after an accepted `start` until `done`.
- `done`  out  1  — one-cycle pulse after the last word is accepted downstream.
- `rd_en`  out  1  — bank read strobe; the read is issued this cycle.
- `rd_addr`  out  ADDR_W  — address presented to all 16 banks.
- `sel_out`  out  5  — mux select, aligned with bank read data; only values 0..15 are driven.
- `mux_q`  in  `D_width`  — output of the 16:1 mux.
- `out_valid`  out  1  — output word valid.
- `out_data`  out  `D_width`  — output word.
- `out_last`  out  1  — qualifies the final word of a run (with `out_valid`).
- `out_ready`  in  1  — downstream accept.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN on `start`.
- RUN → DRAIN after the read for (addr DEPTH-1, bank 15) issues.
- DRAIN → IDLE when the buffer is empty, no read is in flight, and the last word was accepted; `done` pulses on that transition.
- Issue counters: `bank_cnt` 0..15 wraps to 0 and increments `addr_cnt` 0..DEPTH-1. Counters clear on entering RUN.
- Issue rule in RUN: `rd_en`=1 iff `count + inflight − pop < 2`.
  - `count` = buffer occupancy.
  - `inflight` = read issued the previous cycle.
  - `pop` = `out_valid && out_ready`.
- Bank memories have 1-cycle read latency. The cycle after a read issues, `sel_out` equals that read's bank, and `mux_q` is written into the buffer at the end of that cycle.
- Buffer: 2-entry FIFO; `out_data`/`out_valid`/`out_last` come from its head. Simultaneous push and pop is allowed at any occupancy and leaves occupancy unchanged. A push into a full buffer cannot occur, by the issue rule.
- `out_last` is tagged on the word from (DEPTH-1, 15).
- `start` while `busy` is ignored; the run is unaffected.
- `rst` asserted at any time, including mid-run, returns the block to IDLE, flushes the buffer and discards any in-flight read.
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `sel_out`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- Outside RUN, `rd_addr` and `sel_out` hold their last values.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=1, `rd_en`=1, `rd_addr`=0 (bank 0).
- Cycle 2: `sel_out`=0; `mux_q` captured.
- Cycle 3: first `out_valid`.
- With `out_ready` held high: one word per cycle, no bubbles.
  - Last `out_valid` (with `out_last`) at cycle 2+16·DEPTH.
  - `done` pulse and `busy`=0 at cycle 3+16·DEPTH.
- `out_ready` low: at most 2 reads outstanding (buffered + in flight). `rd_en` deasserts in the cycle the limit is reached.
- On `out_ready` rising, `rd_en` reasserts in the same cycle.
- `out_valid`, once high, holds with `out_data` stable until accepted.

## Test plan
- Reset: hold `rst` 3 cycles with `start`=1 → all outputs at reset values, `busy` stays 0.
- Full run, DEPTH=4, bank b addr a preloaded with 16·a+b, `out_ready`=1 → 64 words 0,1,…,63 on consecutive cycles 3..66, `out_last` on word 63 only, `done` at cycle 67.
- Stall: `out_ready`=0 during cycles 5–14 of the same run → buffer holds 2 words, `rd_en`=0 throughout the stall, no word lost or duplicated, sequence still 0..63.
- Random `out_ready` (50%) over DEPTH=64 → 1024 words in order, `out_valid`/`out_data` stable whenever stalled.
- `start` pulsed at cycles 10 and 20 of a run → single run, exactly one `done`.
- `rst` at cycle 30 of a run, then new `start` → clean IDLE after reset, second run outputs the full sequence from word 0.
